// File: rtl/rom_stream_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_stream_reader_pkg                                                |
// | Shared state encoding and default sizing for rom_stream_reader.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rom_stream_reader_pkg;

    localparam int DEFAULT_ADDR_W  = 10;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [2:0] {
        RSR_IDLE = 3'd0,
        RSR_REQ  = 3'd1,
        RSR_WAIT = 3'd2,
        RSR_OUT  = 3'd3,
        RSR_DONE = 3'd4
    } rsr_state_t;

endpackage
`default_nettype wire

// File: rtl/rom_stream_reader_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsr_timeout_cnt                                                      |
// | Counts response-wait cycles; expire flags the last allowed cycle.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rsr_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] r_cnt;

    // Expire is asserted during the TIMEOUT-th enabled cycle so the caller
    // leaves WAIT on exactly that edge.
    assign expire = enable && (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= 8'd0;
        end else if (clear) begin
            r_cnt <= 8'd0;
        end else if (enable) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_stream_reader                                                    |
// | Reads a contiguous ROM byte range over the bus, one read in flight, |
// | and emits it as a valid/ready stream. ROM_STREAM_READER_CHECKSUM_EN  |
// | adds a mod-256 checksum output. Rev 1.0                              |
// +----------------------------------------------------------------------+
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              n_cs,
    output logic              n_rd,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        rdata,
    input  logic              rdata_en,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum
`endif
);

    rsr_state_t      r_state;
    logic [ADDR_W:0] r_remain;
    logic            w_to_clear;
    logic            w_to_en;
    logic            w_expire;

    assign w_to_clear = (r_state != RSR_WAIT);
    assign w_to_en    = (r_state == RSR_WAIT) && !rdata_en;

    rsr_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .n_reset (n_reset),
        .clear   (w_to_clear),
        .enable  (w_to_en),
        .expire  (w_expire)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= RSR_IDLE;
            r_remain  <= '0;
            n_cs      <= 1'b1;
            n_rd      <= 1'b1;
            address   <= '0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                RSR_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        error <= 1'b0;
                        if (length != '0) begin
                            address  <= start_address;
                            r_remain <= length;
                            n_cs     <= 1'b0;
                            n_rd     <= 1'b0;
                            r_state  <= RSR_REQ;
                        end else begin
                            done    <= 1'b1;
                            r_state <= RSR_DONE;
                        end
                    end
                end
                RSR_REQ: begin
                    n_cs    <= 1'b1;
                    n_rd    <= 1'b1;
                    r_state <= RSR_WAIT;
                end
                RSR_WAIT: begin
                    if (rdata_en) begin
                        out_data  <= rdata;
                        out_valid <= 1'b1;
                        r_state   <= RSR_OUT;
                    end else if (w_expire) begin
                        error   <= 1'b1;
                        done    <= 1'b1;
                        r_state <= RSR_DONE;
                    end
                end
                RSR_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_remain  <= r_remain - (ADDR_W + 1)'(1);
                        address   <= address + ADDR_W'(1);
                        if (r_remain == (ADDR_W + 1)'(1)) begin
                            done    <= 1'b1;
                            r_state <= RSR_DONE;
                        end else begin
                            n_cs    <= 1'b0;
                            n_rd    <= 1'b0;
                            r_state <= RSR_REQ;
                        end
                    end
                end
                RSR_DONE: begin
                    busy    <= 1'b0;
                    r_state <= RSR_IDLE;
                end
                default: r_state <= RSR_IDLE;
            endcase
        end
    end

`ifdef ROM_STREAM_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            checksum <= 8'd0;
        end else if (r_state == RSR_IDLE && start) begin
            checksum <= 8'd0;
        end else if (r_state == RSR_OUT && out_ready) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_stream_reader                                                 |
// | Directed self-checking bench with a synchronous-read ROM responder.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic [9:0]  start_address;
    logic [10:0] length;
    logic        busy, done, error, n_cs, n_rd;
    logic [9:0]  address;
    logic [7:0]  rdata;
    logic        rdata_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    logic [7:0]  rom [0:1023];
    logic        resp_en;
    logic        mute;
    logic        stray;
    int          edges = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [9:0]  req_q [$];
    logic [7:0]  byte_q [$];
    int          rise_q [$];
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          long_req = 0;
    logic        prev_cs_low = 1'b0;
    logic        prev_valid = 1'b0;
    int          rb, bb, xb, db, vb;

    always #5 clk = ~clk;

    rom_stream_reader #(
        .ADDR_W  (10),
        .TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .start         (start),
        .start_address (start_address),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .n_cs          (n_cs),
        .n_rd          (n_rd),
        .address       (address),
        .rdata         (rdata),
        .rdata_en      (rdata_en),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    // Responder registers the strobes and answers in the following cycle.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            resp_en <= 1'b0;
            rdata   <= 8'd0;
        end else begin
            resp_en <= !n_cs && !n_rd && !mute;
            rdata   <= rom[address];
        end
    end
    assign rdata_en = resp_en | stray;

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        if (!n_cs) begin
            req_q.push_back(address);
            if (prev_cs_low) long_req++;
        end
        prev_cs_low = !n_cs;
        if (out_valid && out_ready) byte_q.push_back(out_data);
        if (out_valid) valid_cnt++;
        if (out_valid && !prev_valid) rise_q.push_back(edges);
        prev_valid = out_valid;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        rb = req_q.size();
        bb = byte_q.size();
        xb = rise_q.size();
        db = done_cnt;
        vb = valid_cnt;
    endtask

    task automatic start_xfer(input logic [9:0] a, input logic [10:0] l, output int se);
        start_address = a;
        length        = l;
        start         = 1'b1;
        @(posedge clk);
        #1;
        se    = edges;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int de);
        logic found = 1'b0;
        de = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                de    = edges;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        logic found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (out_valid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_valid_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_basic [4];
        int se, de, bad;
        exp_basic = '{8'hF3, 8'h31, 8'h00, 8'h00};
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 7 + 3);
        rom[0] = 8'hF3; rom[1] = 8'h31; rom[2] = 8'h00; rom[3] = 8'h00;
        rom[1023] = 8'hA5;
        n_reset = 1'b0; start = 1'b0; start_address = '0; length = '0;
        out_ready = 1'b1; mute = 1'b0; stray = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_n_cs", 32'(n_cs), 32'd1);
        check("rst_n_rd", 32'(n_rd), 32'd1);
        check("rst_address", 32'(address), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", {29'd0, busy, done, error}, 32'd0);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic four-byte read.
        mark();
        start_xfer(10'd0, 11'd4, se);
        check("basic_req_strobes", {30'd0, n_cs, n_rd}, 32'd0);
        check("basic_busy", 32'(busy), 32'd1);
        wait_done("basic", 40, de);
        check("basic_done_latency", 32'(de - se), 32'd12);
        check("basic_error", 32'(error), 32'd0);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        check("basic_checksum", 32'(checksum), 32'h24);
`endif
        @(posedge clk);
        #1;
        check("basic_busy_fall", {30'd0, busy, done}, 32'd0);
        check("basic_first_valid", 32'(rise_q[xb] - se), 32'd2);
        check("basic_req_count", 32'(req_q.size() - rb), 32'd4);
        check("basic_byte_count", 32'(byte_q.size() - bb), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("basic_addr%0d", k), 32'(req_q[rb + k]), 32'(k));
            check($sformatf("basic_byte%0d", k), 32'(byte_q[bb + k]), 32'(exp_basic[k]));
        end
        check("basic_done_count", 32'(done_cnt - db), 32'd1);
        check("basic_single_req", 32'(long_req), 32'd0);

        // Back-pressure on the second byte.
        mark();
        out_ready = 1'b0;
        start_xfer(10'd0, 11'd4, se);
        for (int i = 0; i < 4; i++) begin
            wait_valid($sformatf("bp%0d", i), 20);
            if (i == 1) begin
                bad = 0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (!out_valid || out_data !== 8'h31 || !n_cs) bad++;
                end
                check("bp_hold_stable", 32'(bad), 32'd0);
                check("bp_no_new_req", 32'(req_q.size() - rb), 32'd2);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        wait_done("bp", 10, de);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_byte_count", 32'(byte_q.size() - bb), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("bp_byte%0d", k), 32'(byte_q[bb + k]), 32'(exp_basic[k]));
        check("bp_req_count", 32'(req_q.size() - rb), 32'd4);

        // Address wrap at the top of the bus range.
        mark();
        start_xfer(10'h3FF, 11'd2, se);
        wait_done("wrap", 20, de);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
        check("wrap_checksum", 32'(checksum), 32'h98);
`endif
        @(posedge clk);
        #1;
        check("wrap_addr0", 32'(req_q[rb]), 32'h3FF);
        check("wrap_addr1", 32'(req_q[rb + 1]), 32'h000);
        check("wrap_byte0", 32'(byte_q[bb]), 32'hA5);
        check("wrap_byte1", 32'(byte_q[bb + 1]), 32'hF3);

        // Response timeout.
        mark();
        mute = 1'b1;
        start_xfer(10'd5, 11'd3, se);
        wait_done("to", 40, de);
        check("to_latency", 32'(de - se), 32'd16);
        check("to_error_at_done", 32'(error), 32'd1);
        @(posedge clk);
        #1;
        check("to_error_sticky", {30'd0, error, busy}, 32'd2);
        check("to_no_valid", 32'(valid_cnt - vb), 32'd0);
        check("to_req_count", 32'(req_q.size() - rb), 32'd1);
        mute = 1'b0;
        mark();
        start_xfer(10'd2, 11'd1, se);
        check("to_error_cleared", 32'(error), 32'd0);
        wait_done("to_next", 20, de);
        @(posedge clk);
        #1;
        check("to_next_byte", 32'(byte_q[bb]), 32'h00);

        // Zero-length transfer.
        mark();
        start_xfer(10'd7, 11'd0, se);
        check("len0_done_busy", {30'd0, done, busy}, 32'd3);
        @(posedge clk);
        #1;
        check("len0_busy_fall", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_no_bus", 32'(req_q.size() - rb), 32'd0);
        check("len0_done_count", 32'(done_cnt - db), 32'd1);

        // Start while busy is ignored.
        mark();
        start_xfer(10'd0, 11'd2, se);
        start_address = 10'h100;
        length        = 11'd5;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("sb", 30, de);
        repeat (6) @(posedge clk);
        #1;
        check("sb_req_count", 32'(req_q.size() - rb), 32'd2);
        check("sb_addr1", 32'(req_q[rb + 1]), 32'd1);
        check("sb_byte_count", 32'(byte_q.size() - bb), 32'd2);
        check("sb_done_count", 32'(done_cnt - db), 32'd1);
        check("sb_idle", 32'(busy), 32'd0);

        // Reset while waiting for a response.
        mute = 1'b1;
        start_xfer(10'd3, 11'd4, se);
        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        check("mr_strobes", {30'd0, n_cs, n_rd}, 32'd3);
        check("mr_address", 32'(address), 32'd0);
        check("mr_out", {23'd0, out_valid, out_data}, 32'd0);
        check("mr_flags", {29'd0, busy, done, error}, 32'd0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        mute    = 1'b0;
        mark();
        stray = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mr_stray_ignored", 32'(valid_cnt - vb), 32'd0);
        mark();
        start_xfer(10'd1, 11'd2, se);
        wait_done("mr_next", 20, de);
        @(posedge clk);
        #1;
        check("mr_next_byte0", 32'(byte_q[bb]), 32'h31);
        check("mr_next_byte1", 32'(byte_q[bb + 1]), 32'h00);
        check("mr_next_error", 32'(error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
